vsm_out_register: RTL and testbench

Output port register of the 4-bit VSM, the write-side counterpart of the input register: captures the internal bus IB when the control unit strobes LoadOut and presents it on DataOut to the external consumer through a valid/ack handshake. A DEPTH-entry FIFO decouples the CPU from a slow consumer. OutFull tells the control unit to stall further OUT instructions. A sticky Overflow flag records any dropped writes.

---
 rtl/vsm_pkg.sv | 37 +++
 rtl/vsm_out_register_if.sv | 45 ++++
 rtl/vsm_out_fifo_mem.sv | 40 ++++
 rtl/vsm_out_register.sv | 120 ++++++++++++
 tb/tb_vsm_out_register.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/vsm_pkg.sv
//------------------------------------------------------------------------------
// Module : vsm_pkg
// Purpose: Types and constants shared by the 4-bit VSM port registers.
//          - VSM_WIDTH      : native data width of the VSM internal bus
//          - vsm_word_t     : one bus word
//          - vsm_out_state_e: occupancy state of the output register FIFO
//          - out_state_of   : maps a FIFO occupancy count onto that state
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package vsm_pkg;

  localparam int VSM_WIDTH = 4;

  typedef logic [VSM_WIDTH-1:0] vsm_word_t;

  typedef enum logic [1:0] {
    OUT_EMPTY = 2'd0,
    OUT_HOLD  = 2'd1,
    OUT_FULL  = 2'd2
  } vsm_out_state_e;

  // The output register keeps no separate state register; its state is a
  // pure function of how many entries are queued.
  function automatic vsm_out_state_e out_state_of(input int count, input int depth);
    if (count == 0)
      return OUT_EMPTY;
    else if (count >= depth)
      return OUT_FULL;
    else
      return OUT_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vsm_out_register_if.sv
//------------------------------------------------------------------------------
// Module : vsm_out_if
// Purpose: Bundle between the control unit / external consumer and the VSM
//          output register.
//   ib        : internal data bus word to be written
//   load_out  : control-unit write strobe
//   out_full  : FIFO full, control unit must stall OUT
//   data_out  : head-of-FIFO word for the consumer
//   out_valid : data_out holds valid data
//   out_ack   : consumer accepts data_out
//   overflow  : sticky flag, a write was dropped
//   clear_ovf : clears overflow
// Modports: master = control unit + consumer side, slave = output register.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vsm_out_if
  import vsm_pkg::*;
#(
  parameter int WIDTH = VSM_WIDTH
);

  logic [WIDTH-1:0] ib;
  logic             load_out;
  logic             out_full;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ack;
  logic             overflow;
  logic             clear_ovf;

  modport master (
    output ib, load_out, out_ack, clear_ovf,
    input  out_full, data_out, out_valid, overflow
  );

  modport slave (
    input  ib, load_out, out_ack, clear_ovf,
    output out_full, data_out, out_valid, overflow
  );

endinterface

`default_nettype wire

// File: rtl/vsm_out_fifo_mem.sv
//------------------------------------------------------------------------------
// Module : vsm_out_fifo_mem
// Purpose: DEPTH x WIDTH storage array of the output register FIFO.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write pointer
//   wdata : word to store
//   raddr : read pointer
//   rdata : word at raddr (asynchronous read)
// The array is deliberately not reset: the top level never presents an
// entry that was not written after the last reset.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vsm_out_fifo_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/vsm_out_register.sv
//------------------------------------------------------------------------------
// Module : vsm_out_register
// Purpose: VSM output port register. Captures the internal bus when the
//          control unit strobes load_out and queues it in a DEPTH-entry FIFO
//          presented to an external consumer via a valid/ack handshake.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards all queued entries
//   bus : vsm_out_if.slave (ib, load_out, out_ack, clear_ovf in;
//         out_full, data_out, out_valid, overflow out)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vsm_out_register
  import vsm_pkg::*;
#(
  parameter int WIDTH = VSM_WIDTH,
  parameter int DEPTH = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  vsm_out_if.slave    bus
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [WIDTH-1:0] r_last;
  logic [WIDTH-1:0] w_head;
  logic             r_valid;
  logic             r_full;
  logic             r_overflow;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  vsm_out_state_e   w_state;

  assign w_state = out_state_of(int'(r_count), DEPTH);

  // A pop needs a queued entry; an ack against an empty FIFO is ignored.
  assign w_pop = (r_count != '0) && bus.out_ack;

  always_comb begin
    w_push = 1'b0;
    w_drop = 1'b0;
    case (w_state)
      OUT_EMPTY,
      OUT_HOLD: w_push = bus.load_out;
      // When full, a write is accepted only into the slot freed by a
      // simultaneous pop; otherwise it is lost and flagged.
      OUT_FULL: begin
        w_push = bus.load_out && w_pop;
        w_drop = bus.load_out && !w_pop;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + 1'b1;
    else if (w_pop && !w_push)
      w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_last     <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      r_full  <= (w_count_next == C_DEPTH);
      // DEPTH is a power of two, so the pointers wrap by natural rollover.
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= w_head;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)
        r_overflow <= 1'b1;
      else if (bus.clear_ovf)
        r_overflow <= 1'b0;
    end
  end

  vsm_out_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (bus.ib),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  // With nothing queued the consumer keeps seeing the last word it took.
  assign bus.data_out  = r_valid ? w_head : r_last;
  assign bus.out_valid = r_valid;
  assign bus.out_full  = r_full;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_vsm_out_register.sv
//------------------------------------------------------------------------------
// Module : tb_vsm_out_register
// Purpose: Self-checking bench for vsm_out_register (WIDTH=4, DEPTH=2).
//          Directed scenarios followed by random traffic, all compared each
//          cycle against a queue-based reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vsm_out_register;
  import vsm_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vsm_out_if #(.WIDTH(4)) bus ();

  vsm_out_register #(
    .WIDTH (4),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: the FIFO contents as a queue, plus the last word popped
  // and the sticky overflow flag.
  logic [3:0] mq[$];
  logic [3:0] m_last;
  logic       m_ovf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic ld, input logic [3:0] d,
                            input logic ack, input logic clr);
    int  sz0;
    bit  popped;
    bit  drop;
    if (r) begin
      mq.delete();
      m_last = 4'h0;
      m_ovf  = 1'b0;
    end else begin
      sz0    = mq.size();
      popped = (sz0 > 0) && ack;
      drop   = 1'b0;
      if (popped)
        m_last = mq.pop_front();
      if (ld) begin
        if (sz0 < DEPTH || popped)
          mq.push_back(d);
        else
          drop = 1'b1;
      end
      if (drop)
        m_ovf = 1'b1;
      else if (clr)
        m_ovf = 1'b0;
    end
  endtask

  task automatic compare(input string tag);
    logic [3:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : m_last;
    chk({tag, ".valid"},    {3'b0, bus.out_valid}, {3'b0, mq.size() > 0});
    chk({tag, ".data"},     bus.data_out,          exp_data);
    chk({tag, ".full"},     {3'b0, bus.out_full},  {3'b0, mq.size() == DEPTH});
    chk({tag, ".overflow"}, {3'b0, bus.overflow},  {3'b0, m_ovf});
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cyc(input logic r, input logic ld, input logic [3:0] d,
                     input logic ack, input logic clr, input string tag);
    rst          = r;
    bus.load_out = ld;
    bus.ib       = d;
    bus.out_ack  = ack;
    bus.clear_ovf = clr;
    @(posedge clk);
    model_step(r, ld, d, ack, clr);
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    m_last = 4'h0;
    m_ovf  = 1'b0;

    // Reset state
    cyc(1, 0, 4'h0, 0, 0, "reset");
    chk("reset_data_zero", bus.data_out, 4'h0);

    // Single load, then hold stable while the consumer stalls
    cyc(0, 1, 4'hA, 0, 0, "load_A");
    chk("load_A_data", bus.data_out, 4'hA);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 4'h0, 0, 0, "hold_A");
      chk("hold_A_valid", {3'b0, bus.out_valid}, 4'h1);
      chk("hold_A_data", bus.data_out, 4'hA);
    end

    // Fill, overflow, drain: consumer sees 3 then 5, never 7
    cyc(1, 0, 4'h0, 0, 0, "rst2");
    cyc(0, 1, 4'h3, 0, 0, "fill_3");
    cyc(0, 1, 4'h5, 0, 0, "fill_5");
    chk("full_set", {3'b0, bus.out_full}, 4'h1);
    cyc(0, 1, 4'h7, 0, 0, "drop_7");
    chk("ovf_set", {3'b0, bus.overflow}, 4'h1);
    chk("head_after_drop", bus.data_out, 4'h3);
    cyc(0, 0, 4'h0, 1, 0, "ack_3");
    chk("second_word", bus.data_out, 4'h5);
    cyc(0, 0, 4'h0, 1, 0, "ack_5");
    chk("empty_keeps_last", bus.data_out, 4'h5);

    // Full FIFO: push with simultaneous pop is accepted
    cyc(1, 0, 4'h0, 0, 0, "rst3");
    cyc(0, 1, 4'h3, 0, 0, "pp_3");
    cyc(0, 1, 4'h5, 0, 0, "pp_5");
    cyc(0, 1, 4'h9, 1, 0, "pp_9_ack");
    chk("pp_full_stays", {3'b0, bus.out_full}, 4'h1);
    chk("pp_no_ovf", {3'b0, bus.overflow}, 4'h0);
    cyc(0, 0, 4'h0, 1, 0, "pp_ack5");
    chk("pp_head_9", bus.data_out, 4'h9);
    cyc(0, 0, 4'h0, 1, 0, "pp_ack9");

    // Streaming 0..F with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 4'(i), 1, 0, "stream");
      chk("stream_data", bus.data_out, 4'(i));
    end
    cyc(0, 0, 4'h0, 1, 0, "stream_tail");

    // Overflow clear, then clear colliding with a drop
    cyc(0, 1, 4'h1, 0, 0, "oc_fill1");
    cyc(0, 1, 4'h2, 0, 0, "oc_fill2");
    cyc(0, 1, 4'h4, 0, 0, "oc_drop");
    cyc(0, 0, 4'h0, 0, 1, "oc_clear");
    chk("ovf_cleared", {3'b0, bus.overflow}, 4'h0);
    cyc(0, 1, 4'h8, 0, 1, "oc_set_wins");
    chk("ovf_set_wins", {3'b0, bus.overflow}, 4'h1);

    // Reset with entries queued, then a fresh load appears alone
    cyc(1, 0, 4'h0, 0, 0, "rst_mid");
    chk("rst_mid_valid", {3'b0, bus.out_valid}, 4'h0);
    chk("rst_mid_data", bus.data_out, 4'h0);
    cyc(0, 1, 4'h6, 0, 0, "after_rst_6");
    chk("after_rst_6_data", bus.data_out, 4'h6);
    cyc(0, 0, 4'h0, 1, 0, "after_rst_ack");
    chk("after_rst_empty", {3'b0, bus.out_valid}, 4'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(99) < 3)  ? 1'b1 : 1'b0,
          ($urandom_range(99) < 60) ? 1'b1 : 1'b0,
          4'($urandom_range(15)),
          ($urandom_range(99) < 45) ? 1'b1 : 1'b0,
          ($urandom_range(99) < 10) ? 1'b1 : 1'b0,
          "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
